// File: rtl/sd_init_sequencer.sv
// SD card SPI-mode bring-up sequencer.
// Sequence: warmup clocks, CMD0, CMD8, CMD55/ACMD41 poll, CMD58, then done or error.
// Optional feature: define SD_INIT_SET_BLKLEN_EN to issue CMD16 (512-byte blocks)
// for standard-capacity cards before DONE.
module sd_init_sequencer #(
    parameter int unsigned WARMUP_CYCLES  = 20480,
    parameter int unsigned ACMD41_RETRIES = 1000
) (
    input  logic        cpuClock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  errorCode,
    output logic        cardV2,
    output logic        cardSDHC,
    output logic        masterReset,
    output logic        spiClockEn,
    output logic        spiClockBS,
    output logic        cmdTransmitBit,
    output logic [5:0]  cmdIndex,
    output logic [31:0] cmdArgument,
    output logic [1:0]  readMode,
    output logic        commStart,
    input  logic        commFinish,
    input  logic [39:0] readResponse,
    input  logic        masterError
);

    localparam int unsigned WarmW  = $clog2(WARMUP_CYCLES + 1);
    localparam int unsigned RetryW = $clog2(ACMD41_RETRIES + 1);

    typedef enum logic [3:0] {
        StIdle, StRst0, StRst1, StWarmup, StCmd0, StCmd8, StCmd55, StAcmd41, StCmd58,
        StDone, StError
`ifdef SD_INIT_SET_BLKLEN_EN
        , StCmd16
`endif
    } state_e;

    // Handshake phase inside a command state.
    typedef enum logic [1:0] {PhIssue, PhWait, PhDrain} phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [WarmW-1:0]  warm_cnt_q, warm_cnt_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [RetryW-1:0] retry_inc;
    logic [39:0]       resp_q, resp_d;
    logic              card_v2_q, card_v2_d;
    logic              card_sdhc_q, card_sdhc_d;
    logic [3:0]        err_code_q, err_code_d;
    logic              start_q, start_prev_q;
    logic              start_edge;
    logic              is_cmd;
    logic [7:0]        r1_single, r1_wide;
    logic              unused_resp;

    assign start_edge  = start_q & ~start_prev_q;
    assign r1_single   = resp_q[7:0];
    assign r1_wide     = resp_q[39:32];
    assign retry_inc   = retry_q + RetryW'(1);
    assign unused_resp = ^{resp_q[31], resp_q[29:12]};
    assign is_cmd      = (state_q == StCmd0) || (state_q == StCmd8) || (state_q == StCmd55) ||
`ifdef SD_INIT_SET_BLKLEN_EN
                         (state_q == StCmd16) ||
`endif
                         (state_q == StAcmd41) || (state_q == StCmd58);

    // Register the start input and its previous value for edge detection.
    always_ff @(posedge cpuClock or negedge reset) begin
        if (!reset) begin
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            start_q      <= start;
            start_prev_q <= start_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge cpuClock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            phase_q     <= PhIssue;
            warm_cnt_q  <= '0;
            retry_q     <= '0;
            resp_q      <= '0;
            card_v2_q   <= 1'b0;
            card_sdhc_q <= 1'b0;
            err_code_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            warm_cnt_q  <= warm_cnt_d;
            retry_q     <= retry_d;
            resp_q      <= resp_d;
            card_v2_q   <= card_v2_d;
            card_sdhc_q <= card_sdhc_d;
            err_code_q  <= err_code_d;
        end
    end

    // Next-state: restart, master error, warmup count, command handshake and branching.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        warm_cnt_d  = warm_cnt_q;
        retry_d     = retry_q;
        resp_d      = resp_q;
        card_v2_d   = card_v2_q;
        card_sdhc_d = card_sdhc_q;
        err_code_d  = err_code_q;
        if (start_edge) begin
            state_d     = StRst0;
            phase_d     = PhIssue;
            card_v2_d   = 1'b0;
            card_sdhc_d = 1'b0;
            err_code_d  = 4'd0;
        end else if (is_cmd && masterError) begin
            state_d    = StError;
            err_code_d = 4'd5;
        end else begin
            case (state_q)
                StRst0: state_d = StRst1;
                StRst1: begin
                    state_d    = StWarmup;
                    warm_cnt_d = '0;
                end
                StWarmup: begin
                    if (warm_cnt_q == WarmW'(WARMUP_CYCLES - 1)) begin
                        state_d = StCmd0;
                        phase_d = PhIssue;
                        retry_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + WarmW'(1);
                    end
                end
                StIdle, StDone, StError: ;
                default: begin
                    case (phase_q)
                        // Never raise commStart while the previous finish is still high.
                        PhIssue: if (!commFinish) phase_d = PhWait;
                        PhWait: begin
                            if (commFinish) begin
                                resp_d  = readResponse;
                                phase_d = PhDrain;
                            end
                        end
                        default: begin
                            if (!commFinish) begin
                                phase_d = PhIssue;
                                case (state_q)
                                    StCmd0: begin
                                        if (r1_single == 8'h01) begin
                                            state_d = StCmd8;
                                        end else begin
                                            state_d    = StError;
                                            err_code_d = 4'd1;
                                        end
                                    end
                                    StCmd8: begin
                                        if (r1_wide == 8'h01 && resp_q[11:0] == 12'h1AA) begin
                                            card_v2_d = 1'b1;
                                            state_d   = StCmd55;
                                        end else if (r1_wide[2]) begin
                                            card_v2_d = 1'b0;
                                            state_d   = StCmd55;
                                        end else begin
                                            state_d    = StError;
                                            err_code_d = 4'd2;
                                        end
                                    end
                                    StCmd55: begin
                                        if (r1_single == 8'h00 || r1_single == 8'h01) begin
                                            state_d = StAcmd41;
                                        end else begin
                                            state_d    = StError;
                                            err_code_d = 4'd4;
                                        end
                                    end
                                    StAcmd41: begin
                                        if (r1_single == 8'h00) begin
`ifdef SD_INIT_SET_BLKLEN_EN
                                            state_d = card_v2_q ? StCmd58 : StCmd16;
`else
                                            state_d = card_v2_q ? StCmd58 : StDone;
`endif
                                        end else if (r1_single == 8'h01) begin
                                            retry_d = retry_inc;
                                            if (retry_inc == RetryW'(ACMD41_RETRIES)) begin
                                                state_d    = StError;
                                                err_code_d = 4'd3;
                                            end else begin
                                                state_d = StCmd55;
                                            end
                                        end else begin
                                            state_d    = StError;
                                            err_code_d = 4'd4;
                                        end
                                    end
                                    StCmd58: begin
                                        if (r1_wide[7]) begin
                                            state_d    = StError;
                                            err_code_d = 4'd4;
                                        end else begin
                                            card_sdhc_d = resp_q[30];
`ifdef SD_INIT_SET_BLKLEN_EN
                                            state_d = resp_q[30] ? StDone : StCmd16;
`else
                                            state_d = StDone;
`endif
                                        end
                                    end
`ifdef SD_INIT_SET_BLKLEN_EN
                                    StCmd16: begin
                                        if (r1_single == 8'h00) begin
                                            state_d = StDone;
                                        end else begin
                                            state_d    = StError;
                                            err_code_d = 4'd6;
                                        end
                                    end
`endif
                                    default: ;
                                endcase
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        masterReset    = 1'b0;
        spiClockEn     = 1'b0;
        cmdIndex       = 6'd0;
        cmdArgument    = 32'd0;
        readMode       = 2'b00;
        commStart      = 1'b0;
        spiClockBS     = 1'b0;
        cmdTransmitBit = 1'b1;
        errorCode      = err_code_q;
        cardV2         = card_v2_q;
        cardSDHC       = card_sdhc_q;
        case (state_q)
            StIdle:         masterReset = 1'b1;
            StRst0, StRst1: begin
                masterReset = 1'b1;
                busy        = 1'b1;
            end
            StWarmup: begin
                busy       = 1'b1;
                spiClockEn = 1'b1;
            end
            StDone:  done  = 1'b1;
            StError: error = 1'b1;
            default: begin
                busy       = 1'b1;
                spiClockEn = 1'b1;
                commStart  = (phase_q == PhWait);
                case (state_q)
                    StCmd8: begin
                        cmdIndex    = 6'd8;
                        cmdArgument = 32'h0000_01AA;
                        readMode    = 2'b10;
                    end
                    StCmd55:  cmdIndex = 6'd55;
                    StAcmd41: begin
                        cmdIndex    = 6'd41;
                        cmdArgument = card_v2_q ? 32'h4000_0000 : 32'd0;
                    end
                    StCmd58: begin
                        cmdIndex = 6'd58;
                        readMode = 2'b10;
                    end
`ifdef SD_INIT_SET_BLKLEN_EN
                    StCmd16: begin
                        cmdIndex    = 6'd16;
                        cmdArgument = 32'h0000_0200;
                    end
`endif
                    default: cmdIndex = 6'd0;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Self-checking bench for sd_init_sequencer: randomized card model plus a
// sequence-level reference model of the expected command stream and outcome.
module tb_sd_init_sequencer;

    localparam int unsigned W = 40;
    localparam int unsigned R = 4;

    logic        cpuClock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error, cardV2, cardSDHC, masterReset, spiClockEn;
    logic        spiClockBS, cmdTransmitBit, commStart;
    logic [3:0]  errorCode;
    logic [5:0]  cmdIndex;
    logic [31:0] cmdArgument;
    logic [1:0]  readMode;
    logic        commFinish = 1'b0;
    logic [39:0] readResponse = '0;
    logic        masterError = 1'b0;

    sd_init_sequencer #(.WARMUP_CYCLES(W), .ACMD41_RETRIES(R)) dut (
        .cpuClock(cpuClock), .reset(reset), .start(start), .busy(busy), .done(done),
        .error(error), .errorCode(errorCode), .cardV2(cardV2), .cardSDHC(cardSDHC),
        .masterReset(masterReset), .spiClockEn(spiClockEn), .spiClockBS(spiClockBS),
        .cmdTransmitBit(cmdTransmitBit), .cmdIndex(cmdIndex), .cmdArgument(cmdArgument),
        .readMode(readMode), .commStart(commStart), .commFinish(commFinish),
        .readResponse(readResponse), .masterError(masterError)
    );

    always #5 cpuClock = ~cpuClock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Card behaviour knobs for the current scenario.
    logic [7:0] m_cmd0_r1;
    int         m_cmd8_kind;   // 0 v2 echo, 1 illegal command (v1), 2 bad echo
    int         m_busy_n;      // ACMD41 replies of 0x01 before 0x00
    logic       m_ccs;
    logic [7:0] m_cmd55_r1;
    int         m_merr;        // command index answered with masterError (63 = none)
    int         acmd_cnt;

    function automatic logic [39:0] make_resp(input logic [5:0] idx);
        logic [31:0] junk;
        logic [7:0]  r;
        junk = $urandom;
        case (idx)
            6'd0:  return {junk, m_cmd0_r1};
            6'd8: begin
                if (m_cmd8_kind == 0) return {8'h01, 20'h0, 12'h1AA};
                else if (m_cmd8_kind == 1) return {8'h05, junk};
                else return {8'h01, 20'h0, 12'h155};
            end
            6'd55: return {junk, m_cmd55_r1};
            6'd41: begin
                r = (acmd_cnt < m_busy_n) ? 8'h01 : 8'h00;
                acmd_cnt++;
                return {junk, r};
            end
            6'd58: return {8'h00, (m_ccs ? 32'hC0FF_8000 : 32'h80FF_8000)};
            6'd16: return {junk, 8'h00};
            default: return {junk, 8'hFF};
        endcase
    endfunction

    // Card / command-master model, driven on the falling edge.
    initial begin
        int phase = 0;
        int dly = 0;
        int hold = 0;
        logic [5:0] cmd = '0;
        forever begin
            @(negedge cpuClock);
            if (!reset) begin
                commFinish  = 1'b0;
                masterError = 1'b0;
                phase       = 0;
            end else begin
                case (phase)
                    0: if (commStart) begin
                        cmd   = cmdIndex;
                        dly   = $urandom_range(0, 3);
                        phase = 1;
                    end
                    1: begin
                        if (dly > 0) dly--;
                        else if (int'(cmd) == m_merr) begin
                            masterError = 1'b1;
                            phase       = 3;
                        end else begin
                            readResponse = make_resp(cmd);
                            commFinish   = 1'b1;
                            hold         = $urandom_range(1, 3);
                            phase        = 2;
                        end
                    end
                    2: begin
                        if (hold > 1) hold--;
                        else begin
                            commFinish = 1'b0;
                            phase      = 0;
                        end
                    end
                    3: begin
                        masterError = 1'b0;
                        phase       = 4;
                    end
                    default: if (!commStart) phase = 0;
                endcase
            end
        end
    end

    // Command log and handshake monitor, sampled mid-low-phase.
    logic [5:0]  log_idx[$];
    logic [31:0] log_arg[$];
    logic [1:0]  log_mode[$];
    initial begin
        logic prev_cs = 1'b0;
        forever begin
            @(negedge cpuClock);
            #2;
            if (commStart && !prev_cs) begin
                log_idx.push_back(cmdIndex);
                log_arg.push_back(cmdArgument);
                log_mode.push_back(readMode);
                check_eq("start_while_finish", commFinish, 1'b0);
            end
            prev_cs = commStart;
        end
    end

    // Reference model: expected command stream and outcome from the card knobs.
    logic [5:0]  exp_idx[$];
    logic [31:0] exp_arg[$];
    logic [1:0]  exp_mode[$];
    logic        exp_done, exp_v2, exp_sdhc;
    logic [3:0]  exp_code;

    function automatic bit want(input int idx, input logic [31:0] arg, input logic [1:0] mode);
        exp_idx.push_back(6'(idx));
        exp_arg.push_back(arg);
        exp_mode.push_back(mode);
        return idx == m_merr;
    endfunction

    task automatic model_expect();
        exp_idx.delete(); exp_arg.delete(); exp_mode.delete();
        exp_done = 1'b0; exp_v2 = 1'b0; exp_sdhc = 1'b0; exp_code = 4'd0;
        if (want(0, 32'd0, 2'b00)) begin exp_code = 4'd5; return; end
        if (m_cmd0_r1 != 8'h01) begin exp_code = 4'd1; return; end
        if (want(8, 32'h1AA, 2'b10)) begin exp_code = 4'd5; return; end
        if (m_cmd8_kind == 2) begin exp_code = 4'd2; return; end
        exp_v2 = (m_cmd8_kind == 0);
        for (int k = 0; k < 1000; k++) begin
            if (want(55, 32'd0, 2'b00)) begin exp_code = 4'd5; return; end
            if (want(41, exp_v2 ? 32'h4000_0000 : 32'd0, 2'b00)) begin
                exp_code = 4'd5; return;
            end
            if (k >= m_busy_n) break;
            if (k + 1 == R) begin exp_code = 4'd3; return; end
        end
        if (exp_v2) begin
            if (want(58, 32'd0, 2'b10)) begin exp_code = 4'd5; return; end
            exp_sdhc = m_ccs;
        end
`ifdef SD_INIT_SET_BLKLEN_EN
        if (!exp_sdhc) begin
            if (want(16, 32'h200, 2'b00)) begin exp_code = 4'd5; return; end
        end
`endif
        exp_done = 1'b1;
    endtask

    task automatic set_model(input logic [7:0] r0, input int kind, input int bn,
                             input logic ccs, input logic [7:0] c55, input int merr);
        m_cmd0_r1 = r0; m_cmd8_kind = kind; m_busy_n = bn;
        m_ccs = ccs; m_cmd55_r1 = c55; m_merr = merr;
    endtask

    task automatic start_seq(input bit restart);
        int cyc = 0;
        int mr_cnt = 0;
        acmd_cnt = 0;
        log_idx.delete(); log_arg.delete(); log_mode.delete();
        @(negedge cpuClock);
        start = 1'b1;
        while (!spiClockEn && cyc < 50) begin
            @(negedge cpuClock);
            if (masterReset) mr_cnt++;
            cyc++;
        end
        start = 1'b0;
        check_eq("warmup_reached", spiClockEn, 1'b1);
        if (restart) check_eq("mreset_cycles", mr_cnt, 2);
        check_eq("clr_v2", cardV2, 1'b0);
        check_eq("clr_sdhc", cardSDHC, 1'b0);
        check_eq("clr_code", errorCode, 4'd0);
        check_eq("busy_warm", busy, 1'b1);
        cyc = 0;
        while (!commStart && cyc < int'(W) + 20) begin
            @(negedge cpuClock);
            cyc++;
        end
        check_eq("warmup_len", cyc, W + 1);
    endtask

    task automatic run_scenario(input bit restart);
        int cyc = 0;
        model_expect();
        start_seq(restart);
        while (!(done || error) && cyc < 4000) begin
            @(negedge cpuClock);
            cyc++;
        end
        check_eq("finished", done | error, 1'b1);
        repeat (20) @(negedge cpuClock);
        check_eq("done", done, exp_done);
        check_eq("error", error, exp_code != 4'd0);
        check_eq("errorCode", errorCode, exp_code);
        check_eq("cardV2", cardV2, exp_v2);
        check_eq("cardSDHC", cardSDHC, exp_sdhc);
        check_eq("busy_end", busy, 1'b0);
        check_eq("sclk_end", spiClockEn, 1'b0);
        check_eq("commStart_end", commStart, 1'b0);
        check_eq("tied", {spiClockBS, cmdTransmitBit}, 2'b01);
        check_eq("n_cmds", log_idx.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size() && i < log_idx.size(); i++) begin
            check_eq($sformatf("cmd%0d_idx", i), log_idx[i], exp_idx[i]);
            check_eq($sformatf("cmd%0d_arg", i), log_arg[i], exp_arg[i]);
            check_eq($sformatf("cmd%0d_mode", i), log_mode[i], exp_mode[i]);
        end
    endtask

    initial begin
        int kind;
        int found;
        set_model(8'h01, 0, 0, 1'b0, 8'h01, 63);
        #12;
        check_eq("rst_masterReset", masterReset, 1'b1);
        check_eq("rst_outputs", {busy, done, error, errorCode, cardV2, cardSDHC, spiClockEn,
                                 commStart, cmdIndex, readMode}, '0);
        check_eq("rst_cmdTransmitBit", cmdTransmitBit, 1'b1);
        @(negedge cpuClock);
        reset = 1'b1;
        repeat (2) @(negedge cpuClock);

        // Directed: v2 SDHC, v1, CMD0 bad, ACMD41 timeout, master error, v2 SDSC, CMD8 bad.
        set_model(8'h01, 0, 2, 1'b1, 8'h01, 63); run_scenario(1'b0);
        set_model(8'h01, 1, 0, 1'b0, 8'h01, 63); run_scenario(1'b1);
        set_model(8'hFF, 0, 0, 1'b0, 8'h01, 63); run_scenario(1'b1);
        set_model(8'h01, 0, 100, 1'b0, 8'h01, 63); run_scenario(1'b1);
        set_model(8'h01, 0, 0, 1'b0, 8'h01, 8); run_scenario(1'b1);
        set_model(8'h01, 0, 1, 1'b0, 8'h00, 63); run_scenario(1'b1);
        set_model(8'h01, 2, 0, 1'b0, 8'h01, 63); run_scenario(1'b1);

        for (int n = 0; n < 10; n++) begin
            kind = $urandom_range(0, 5);
            set_model(($urandom_range(0, 7) == 0) ? 8'hFF : 8'h01,
                      (kind < 3) ? 0 : ((kind < 5) ? 1 : 2),
                      $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 1)), 63);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: m_merr = 0;
                    1: m_merr = 8;
                    2: m_merr = 55;
                    default: m_merr = 41;
                endcase
            end
            run_scenario(1'b1);
        end

        // Asynchronous reset while the master is busy with an ACMD41.
        set_model(8'h01, 0, 100, 1'b0, 8'h01, 63);
        start_seq(1'b1);
        found = 0;
        for (int c = 0; c < 3000 && found == 0; c++) begin
            @(negedge cpuClock);
            if (commStart && cmdIndex == 6'd41) found = 1;
        end
        check_eq("reach_acmd41", found, 1);
        #3;
        reset = 1'b0;
        #1;
        check_eq("arst_commStart", commStart, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_masterReset", masterReset, 1'b1);
        check_eq("arst_sclk", spiClockEn, 1'b0);
        check_eq("arst_cmdIndex", cmdIndex, 6'd0);
        repeat (3) @(negedge cpuClock);
        reset = 1'b1;
        repeat (2) @(negedge cpuClock);
        set_model(8'h01, 0, 1, 1'b1, 8'h01, 63); run_scenario(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
